// File: rtl/nn_pkg.sv
// Purpose: shared types, defaults and helpers for the classifier output stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: state_e (ACCUM/HOLD), DEFAULT_DATA_W, clog2_min1() used to size
// index/counter fields so a single-class build still gets a 1-bit field.
package nn_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int DEFAULT_DATA_W = 32;

  // ceil(log2(n)), but never less than 1.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/argmax_cmp_stage.sv
// Purpose: running max / runner-up compare-and-update slice with result registers.
// Latency: running state updates on each accepted beat; results load on the frame-end beat.
// Backpressure: none here; the parent only pulses i_beat/i_done on accepted beats.
// Ports: i_beat  accepted element strobe     i_first first element of frame
//        i_done  frame-end beat (implies i_beat)  i_idx position of element in frame
//        i_data  signed element               o_index/o_value registered result
//        o_margin (STREAM_ARGMAX_MARGIN_EN only) registered max minus runner-up
// Optional: `define STREAM_ARGMAX_MARGIN_EN adds the runner-up tracker and o_margin.
module argmax_cmp_stage
  import nn_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_beat,
  input  logic              i_first,
  input  logic              i_done,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_data,
  output logic [IDX_W-1:0]  o_index,
  output logic [DATA_W-1:0] o_value
`ifdef STREAM_ARGMAX_MARGIN_EN
  ,
  output logic [DATA_W:0]   o_margin
`endif
);

  logic [DATA_W-1:0] r_max_val;
  logic [IDX_W-1:0]  r_max_idx;
  logic [DATA_W-1:0] w_max_val;
  logic [IDX_W-1:0]  w_max_idx;
  logic              w_new_max;

  // Strict compare: ties keep the earlier (lower) index.
  assign w_new_max = $signed(i_data) > $signed(r_max_val);

  // Next max including the current beat, so the frame-end beat can load the
  // result registers directly without an extra cycle.
  always_comb begin
    w_max_val = r_max_val;
    w_max_idx = r_max_idx;
    if (i_first) begin
      w_max_val = i_data;
      w_max_idx = '0;
    end else if (w_new_max) begin
      w_max_val = i_data;
      w_max_idx = i_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_val <= '0;
      r_max_idx <= '0;
      o_value   <= '0;
      o_index   <= '0;
    end else begin
      if (i_beat) begin
        r_max_val <= w_max_val;
        r_max_idx <= w_max_idx;
      end
      if (i_done) begin
        o_value <= w_max_val;
        o_index <= w_max_idx;
      end
    end
  end

`ifdef STREAM_ARGMAX_MARGIN_EN
  // Runner-up = largest element other than one instance of the max. r_sec_vld
  // stays low until a second element arrives, so a single-element frame
  // yields margin 0 and later small values are not masked by a stale seed.
  logic [DATA_W-1:0] r_sec_val;
  logic              r_sec_vld;
  logic [DATA_W-1:0] w_sec_val;
  logic              w_sec_vld;
  logic [DATA_W:0]   w_margin;

  always_comb begin
    w_sec_val = r_sec_val;
    w_sec_vld = r_sec_vld;
    if (i_first) begin
      w_sec_val = '0;
      w_sec_vld = 1'b0;
    end else if (w_new_max) begin
      w_sec_val = r_max_val;
      w_sec_vld = 1'b1;
    end else if (!r_sec_vld || ($signed(i_data) >= $signed(r_sec_val))) begin
      // Includes a value equal to the max, which gives an exact tie margin 0.
      w_sec_val = i_data;
      w_sec_vld = 1'b1;
    end
  end

  // One extra bit so max - runner-up can never overflow (result is >= 0).
  always_comb begin
    w_margin = '0;
    if (w_sec_vld) begin
      w_margin = {w_max_val[DATA_W-1], w_max_val} - {w_sec_val[DATA_W-1], w_sec_val};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_val <= '0;
      r_sec_vld <= 1'b0;
      o_margin  <= '0;
    end else begin
      if (i_beat) begin
        r_sec_val <= w_sec_val;
        r_sec_vld <= w_sec_vld;
      end
      if (i_done) begin
        o_margin <= w_margin;
      end
    end
  end
`endif

endmodule

// File: rtl/stream_argmax.sv
// Purpose: streaming arg-max over framed activations (classifier output stage).
// Latency: out_valid rises the cycle after the frame's last beat is accepted.
// Backpressure: result held in HOLD until out_ready; in_ready is low while holding.
// Ports: in_valid/in_ready/in_data/in_last  element stream (one element per beat)
//        out_valid/out_ready                result handshake
//        out_index/out_value/out_len_err    registered result, stable while out_valid
//        out_margin (STREAM_ARGMAX_MARGIN_EN only) max minus runner-up, unsigned
// Optional: `define STREAM_ARGMAX_MARGIN_EN enables out_margin.
module stream_argmax
  import nn_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = clog2_min1(NUM_CLASSES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_value,
  output logic              out_len_err
`ifdef STREAM_ARGMAX_MARGIN_EN
  ,
  output logic [DATA_W:0]   out_margin
`endif
);

  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_CLASSES - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] r_count;
  logic             r_len_err;
  logic             w_fire;
  logic             w_last_slot;
  logic             w_done;

  assign w_fire      = in_valid & in_ready;
  assign w_last_slot = (r_count == LAST_SLOT);
  // Frame closes on in_last or when the frame is full, whichever is first.
  assign w_done      = w_fire & (in_last | w_last_slot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = 1'b1;
        if (w_done) w_state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ACCUM;
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_len_err <= 1'b0;
    end else begin
      if (w_done) begin
        r_count   <= '0;
        // Early in_last (short) or full frame without in_last (long) both flag.
        r_len_err <= in_last ^ w_last_slot;
      end else if (w_fire) begin
        r_count <= r_count + IDX_W'(1'b1);
      end
    end
  end

  assign out_len_err = r_len_err;

  argmax_cmp_stage #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_beat   (w_fire),
    .i_first  (r_count == '0),
    .i_done   (w_done),
    .i_idx    (r_count),
    .i_data   (in_data),
    .o_index  (out_index),
    .o_value  (out_value)
`ifdef STREAM_ARGMAX_MARGIN_EN
    ,
    .o_margin (out_margin)
`endif
  );

endmodule

// File: tb/tb_stream_argmax.sv
// Purpose: self-checking bench for stream_argmax (scoreboard + frame-level model).
// Latency: checks out_valid appears the cycle after each frame-end beat.
// Backpressure: drives held out_ready low phases and random out_ready.
`timescale 1ns/1ps
module tb_stream_argmax;

  localparam int DW = 32;
  localparam int NC = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic [DW-1:0] out_value;
  logic          out_len_err;
`ifdef STREAM_ARGMAX_MARGIN_EN
  logic [DW:0]   out_margin;
`endif

  always #5 clk = ~clk;

  stream_argmax #(
    .DATA_W      (DW),
    .NUM_CLASSES (NC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .out_value   (out_value),
    .out_len_err (out_len_err)
`ifdef STREAM_ARGMAX_MARGIN_EN
    ,
    .out_margin  (out_margin)
`endif
  );

  typedef struct {
    int unsigned   idx;
    logic [DW-1:0] val;
    logic          err;
    logic [DW:0]   margin;
  } exp_t;

  exp_t                 exp_q[$];
  logic signed [DW-1:0] frame_q[$];
  int                   checks = 0;
  int                   errors = 0;
  bit                   pend_end = 1'b0;
  int                   ready_mode = 1;
  int                   hold_cnt = 0;

  int f1 [10] = '{3, -1, 7, 7, 2, 0, 5, -8, 1, 4};
  int f3 [3]  = '{-5, 9, 2};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: collects accepted elements, and when a frame closes
  // computes the arg-max, runner-up and length flag straight from the list.
  task automatic model_accept(input logic signed [DW-1:0] d, input logic l);
    exp_t                 e;
    int                   n;
    logic signed [DW-1:0] mx;
    logic signed [DW-1:0] sec;
    bit                   have_sec;
    frame_q.push_back(d);
    n = frame_q.size();
    if (l || n == NC) begin
      e.idx = 0;
      for (int i = 1; i < n; i++) if (frame_q[i] > frame_q[e.idx]) e.idx = i;
      mx = frame_q[e.idx];
      e.val = mx;
      have_sec = 1'b0;
      sec = '0;
      for (int i = 0; i < n; i++) begin
        if (i != int'(e.idx) && (!have_sec || frame_q[i] > sec)) begin
          sec = frame_q[i];
          have_sec = 1'b1;
        end
      end
      e.margin = have_sec ? (DW+1)'(longint'(mx) - longint'(sec)) : '0;
      e.err = l ^ (n == NC);
      exp_q.push_back(e);
      pend_end = 1'b1;
      frame_q.delete();
    end
  endtask

  // Called at a negedge; returns at a negedge with in_valid low.
  task automatic send_beat(input logic [DW-1:0] d, input logic l, input int idle, output int stalls);
    logic r;
    stalls = 0;
    in_valid = 1'b0;
    repeat (idle) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      r = in_ready;
      @(posedge clk);
      if (r) begin
        model_accept(d, l);
        break;
      end
      stalls++;
      if (stalls > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: beat not accepted after %0d cycles, expected acceptance", stalls);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  function automatic logic [DW-1:0] rand_val();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'h7fff_ffff;
      2:       return DW'(int'($urandom_range(0, 8)) - 4);
      default: return $urandom();
    endcase
  endfunction

  // out_ready driver, updated just after the rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'($urandom_range(0, 1));
      1: out_ready = 1'b1;
      default: begin
        if (out_valid) begin
          hold_cnt++;
          out_ready = (hold_cnt > 5);
        end else begin
          hold_cnt  = 0;
          out_ready = 1'b0;
        end
      end
    endcase
  end

  // Monitor / scoreboard.
  logic          prev_vld = 1'b0;
  logic          prev_rdy = 1'b0;
  logic [IW-1:0] prev_idx;
  logic [DW-1:0] prev_val;
  logic          prev_err;
`ifdef STREAM_ARGMAX_MARGIN_EN
  logic [DW:0]   prev_margin;
`endif
  exp_t          mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (pend_end) begin
        check("latency_out_valid", out_valid, 1);
        pend_end = 1'b0;
      end else if (!prev_vld) begin
        check("no_spurious_valid", out_valid, 0);
      end
      check("in_ready_vs_hold", in_ready, !out_valid);
      if (prev_vld && !prev_rdy) begin
        check("hold_valid", out_valid, 1);
        check("hold_index_stable", out_index, prev_idx);
        check("hold_value_stable", out_value, prev_val);
        check("hold_len_err_stable", out_len_err, prev_err);
`ifdef STREAM_ARGMAX_MARGIN_EN
        check("hold_margin_stable", out_margin, prev_margin);
`endif
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got index %0d value 0x%0h, expected no result", out_index, out_value);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_index", out_index, mon_e.idx);
          check("out_value", out_value, mon_e.val);
          check("out_len_err", out_len_err, mon_e.err);
`ifdef STREAM_ARGMAX_MARGIN_EN
          check("out_margin", out_margin, mon_e.margin);
`endif
        end
      end
      prev_vld = out_valid;
      prev_rdy = out_ready;
      prev_idx = out_index;
      prev_val = out_value;
      prev_err = out_len_err;
`ifdef STREAM_ARGMAX_MARGIN_EN
      prev_margin = out_margin;
`endif
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_value", out_value, 0);
    check("rst_out_len_err", out_len_err, 0);
`ifdef STREAM_ARGMAX_MARGIN_EN
    check("rst_out_margin", out_margin, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Reference frame, ties keep lower index.
    ready_mode = 1;
    for (int i = 0; i < 10; i++) send_beat(DW'(f1[i]), i == 9, 0, st);
    // All most-negative values.
    for (int i = 0; i < 10; i++) send_beat(32'h8000_0000, i == 9, 0, st);
    // Short frame.
    for (int i = 0; i < 3; i++) send_beat(DW'(f3[i]), i == 2, 0, st);
    drain();

    // Backpressure: result held 5 cycles, next frame's first beat waits.
    ready_mode = 2;
    for (int i = 0; i < 10; i++) send_beat(rand_val(), i == 9, 0, st);
    send_beat(rand_val(), 1'b0, 0, st);
    check("bp_first_beat_stalls", st, 6);
    for (int i = 1; i < 10; i++) send_beat(rand_val(), i == 9, 0, st);
    drain();

    // 12 beats without in_last, closed by a final in_last beat.
    ready_mode = 1;
    for (int i = 0; i < 13; i++) send_beat(rand_val(), i == 12, 0, st);
    drain();

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 5; i++) send_beat(rand_val(), 1'b0, 0, st);
    rst_n = 1'b0;
    frame_q.delete();
    repeat (2) @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_out_valid", out_valid, 0);
    for (int i = 0; i < 10; i++) send_beat(rand_val(), i == 9, 0, st);
    drain();

    // Randomized frames, gaps and backpressure.
    ready_mode = 0;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int b = 0; b < len; b++)
        send_beat(rand_val(), (b == len - 1) && ($urandom_range(0, 3) != 0), $urandom_range(0, 2), st);
    end
    send_beat(rand_val(), 1'b1, 0, st);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
